// File: rtl/instruction_fetch.sv
// Instruction fetch unit.
// Keeps a fetch PC and issues in-order requests to instruction memory.
// Responses are queued in a small FIFO for the datapath.
// A credit rule keeps buffered entries plus in-flight requests within DEPTH,
// so the FIFO can never overflow.
// A redirect empties the FIFO, moves both PCs to the target, and marks every
// in-flight request to be discarded when its response returns.
//
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   halt                           stops issue of new requests (RUN <-> HALTED)
//   redirect_valid, redirect_pc    branch/jump redirect; redirect_pc[1:0] are ignored
//   imem_req_valid/ready/addr      request channel to instruction memory
//   imem_rsp_valid/data            in-order response channel; always accepted
//   inst_valid/ready/data/pc       instruction channel to the datapath
//   fetch_idle                     nothing in flight, FIFO empty, and not in reset state
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  output logic        fetch_idle
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StRst, StRun, StHalted} state_e;

  state_e            r_state;
  logic [63:0]       r_fetch_pc;
  logic [63:0]       r_rsp_pc;
  logic [CntW-1:0]   r_outstanding;
  logic [CntW-1:0]   r_discard_cnt;
  logic [CntW-1:0]   r_buf_count;
  logic [PtrW-1:0]   r_head;
  logic [PtrW-1:0]   r_tail;
  logic [31:0]       r_buf_data [DEPTH];
  logic [63:0]       r_buf_pc   [DEPTH];

  logic              w_credit_ok;
  logic              w_req_fire;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic [CntW-1:0]   w_outstanding_d;
  logic [63:0]       w_redirect_pc;
  logic              w_unused_redirect_lsb;

  // Pointer increment that wraps at DEPTH, so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign w_redirect_pc         = {redirect_pc[63:2], 2'b00};
  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffered words plus in-flight requests (including ones to be discarded)
  // must stay below DEPTH before another request may go out.
  assign w_credit_ok = ({1'b0, r_buf_count} + {1'b0, r_outstanding}) < (CntW + 1)'(DEPTH);

  assign imem_req_valid = (r_state == StRun) && !redirect_valid && w_credit_ok;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign inst_valid = (r_buf_count != '0);
  assign inst_data  = r_buf_data[r_head];
  assign inst_pc    = r_buf_pc[r_head];
  assign w_pop      = inst_valid && inst_ready;

  // A response in the redirect cycle is dropped without touching discard_cnt;
  // it is already excluded from the outstanding count loaded into discard_cnt.
  assign w_drop = imem_rsp_valid && !redirect_valid && (r_discard_cnt != '0);
  assign w_push = imem_rsp_valid && !redirect_valid && (r_discard_cnt == '0);

  assign fetch_idle = (r_state != StRst) && (r_outstanding == '0) && (r_buf_count == '0);

  always_comb begin
    w_outstanding_d = r_outstanding;
    if (w_req_fire) begin
      w_outstanding_d = w_outstanding_d + CntW'(1);
    end
    if (imem_rsp_valid) begin
      w_outstanding_d = w_outstanding_d - CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StRst;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
      r_buf_count   <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      case (r_state)
        StRst:    r_state <= StRun;
        StRun:    if (halt) r_state <= StHalted;
        StHalted: if (!halt) r_state <= StRun;
        default:  r_state <= StRst;
      endcase

      r_outstanding <= w_outstanding_d;

      if (redirect_valid) begin
        r_fetch_pc    <= w_redirect_pc;
        r_rsp_pc      <= w_redirect_pc;
        r_discard_cnt <= w_outstanding_d;
        r_buf_count   <= '0;
        r_head        <= '0;
        r_tail        <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 64'd4;
        end
        if (w_drop) begin
          r_discard_cnt <= r_discard_cnt - CntW'(1);
        end
        if (w_push) begin
          r_buf_data[r_tail] <= imem_rsp_data;
          r_buf_pc[r_tail]   <= r_rsp_pc;
          r_tail             <= ptr_inc(r_tail);
          r_rsp_pc           <= r_rsp_pc + 64'd4;
        end
        if (w_pop) begin
          r_head <= ptr_inc(r_head);
        end
        case ({w_push, w_pop})
          2'b10:   r_buf_count <= r_buf_count + CntW'(1);
          2'b01:   r_buf_count <= r_buf_count - CntW'(1);
          default: r_buf_count <= r_buf_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch (DEPTH=2, RESET_PC=0).
// The stimulus pushes the expected request addresses and delivered
// instructions into queues. A monitor pops these queues and compares them
// against every request handshake and every instruction pop.
// The memory model returns {8'hA5, addr[23:0]} after a programmable latency.
module tb_instruction_fetch;

  logic        clock;
  logic        reset_n;
  logic        halt;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        fetch_idle;

  instruction_fetch #(
    .RESET_PC (64'd0),
    .DEPTH    (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_idle     (fetch_idle)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard queues
  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } inst_t;

  logic [63:0] exp_req[$];
  inst_t       exp_inst[$];

  task automatic push_inst(input logic [63:0] pc, input logic [31:0] data);
    inst_t e;
    e.pc   = pc;
    e.data = data;
    exp_inst.push_back(e);
  endtask

  // Monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          check("unexpected_req_addr", imem_req_addr, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          check("req_addr", imem_req_addr, exp_req.pop_front());
        end
      end
      if (inst_valid && inst_ready) begin
        if (exp_inst.size() == 0) begin
          check("unexpected_inst_pc", inst_pc, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          inst_t e;
          e = exp_inst.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", {32'd0, inst_data}, {32'd0, e.data});
        end
      end
    end
  end

  // Memory model
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    mem_lat = 1;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      if (reset_n && imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      end
      @(posedge clock);
      cyc++;
      #1;
      if (reset_n && mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = {8'hA5, mq[0].addr[23:0]};
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge reset_n);
      imem_rsp_valid = 1'b0;
      mq.delete();
    end
  end

  // Pull reset low between edges, check the reset outputs, then release it.
  task automatic do_reset();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_fetch_idle", {63'd0, fetch_idle}, 64'd0);
    check("rst_req_addr", imem_req_addr, 64'd0);
    check("rst_inst_data", {32'd0, inst_data}, 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_state_not_idle", {63'd0, fetch_idle}, 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Allow n request handshakes, then stop by dropping ready or raising halt.
  task automatic run_fires(input int n, input bit stop_halt);
    int seen = 0;
    int guard = 0;
    imem_req_ready = 1'b1;
    while (seen < n && guard < 200) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) seen++;
      guard++;
    end
    if (seen < n) fail_now("run_fires");
    @(posedge clock);
    #1;
    if (stop_halt) halt = 1'b1;
    else imem_req_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    @(negedge clock);
    while (!fetch_idle && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!fetch_idle) fail_now(name);
    check({name, "_req_left"}, 64'(exp_req.size()), 64'd0);
    check({name, "_inst_left"}, 64'(exp_inst.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic count_fires(input int cycles, output int fires);
    fires = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) fires++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fires;
    reset_n        = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;

    // Streaming
    do_reset();
    check("idle_after_reset", {63'd0, fetch_idle}, 64'd1);
    mem_lat    = 1;
    inst_ready = 1'b1;
    exp_req.push_back(64'h0);
    exp_req.push_back(64'h4);
    exp_req.push_back(64'h8);
    exp_req.push_back(64'hC);
    push_inst(64'h0, 32'hA500_0000);
    push_inst(64'h4, 32'hA500_0004);
    push_inst(64'h8, 32'hA500_0008);
    push_inst(64'hC, 32'hA500_000C);
    run_fires(4, 1'b0);
    drain("stream");

    // Backpressure
    do_reset();
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    exp_req.push_back(64'h0);
    exp_req.push_back(64'h4);
    exp_req.push_back(64'h8);
    push_inst(64'h0, 32'hA500_0000);
    push_inst(64'h4, 32'hA500_0004);
    push_inst(64'h8, 32'hA500_0008);
    count_fires(8, fires);
    check("bp_fire_count", 64'(fires), 64'd2);
    check("bp_req_valid_low", {63'd0, imem_req_valid}, 64'd0);
    check("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
    @(posedge clock);
    #1;
    inst_ready = 1'b1;
    run_fires(1, 1'b0);
    drain("backpressure");

    // Redirect with two requests in flight
    do_reset();
    mem_lat    = 3;
    inst_ready = 1'b1;
    exp_req.push_back(64'h0);
    exp_req.push_back(64'h4);
    push_inst(64'h0, 32'hA500_0000);
    push_inst(64'h4, 32'hA500_0004);
    run_fires(2, 1'b0);
    drain("redir_pre");
    exp_req.push_back(64'h8);
    exp_req.push_back(64'hC);
    run_fires(2, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    imem_req_ready = 1'b1;
    #1;
    check("redir_req_valid_low", {63'd0, imem_req_valid}, 64'd0);
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    exp_req.push_back(64'h100);
    push_inst(64'h100, 32'hA500_0100);
    run_fires(1, 1'b0);
    drain("redirect");

    // Halt after the request for 4 is accepted
    do_reset();
    mem_lat    = 1;
    inst_ready = 1'b1;
    exp_req.push_back(64'h0);
    exp_req.push_back(64'h4);
    push_inst(64'h0, 32'hA500_0000);
    push_inst(64'h4, 32'hA500_0004);
    run_fires(2, 1'b1);
    count_fires(8, fires);
    check("halt_fire_count", 64'(fires), 64'd0);
    check("halt_idle", {63'd0, fetch_idle}, 64'd1);
    check("halt_inst_left", 64'(exp_inst.size()), 64'd0);
    @(posedge clock);
    #1;
    halt = 1'b0;
    exp_req.push_back(64'h8);
    push_inst(64'h8, 32'hA500_0008);
    run_fires(1, 1'b0);
    drain("halt");

    // Address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_req.push_back(64'h0);
    push_inst(64'hFFFF_FFFF_FFFF_FFFC, 32'hA5FF_FFFC);
    push_inst(64'h0, 32'hA500_0000);
    run_fires(2, 1'b0);
    drain("wrap");

    // Asynchronous reset mid-stream
    inst_ready = 1'b0;
    exp_req.push_back(64'h4);
    run_fires(1, 1'b0);
    repeat (2) @(negedge clock);
    check("pre_rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("pre_rst_inst_valid", {63'd0, inst_valid}, 64'd1);
    do_reset();
    inst_ready = 1'b1;
    exp_req.push_back(64'h0);
    push_inst(64'h0, 32'hA500_0000);
    run_fires(1, 1'b0);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
